// File: rtl/mvu_pe_xnor_popcount_acc.sv
// Binarized SIMD PE: per-beat XNOR + popcount, accumulated over SF beats into one result.
// Define XNOR_BIPOLAR_EN to emit the signed {-1,+1} dot product instead of the match count.
module mvu_pe_xnor_popcount_acc #(
  parameter int unsigned SIMD  = 8,
  parameter int unsigned SF    = 4,
  parameter int unsigned TDstI = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [SIMD-1:0]  in_act,
  input  logic [SIMD-1:0]  in_wgt,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [TDstI-1:0] out_dat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned AccW = $clog2(SIMD * SF + 1);
`ifdef XNOR_BIPOLAR_EN
  localparam int unsigned MinW = AccW + 1;
`else
  localparam int unsigned MinW = AccW;
`endif
  localparam int unsigned CntW = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(SF - 1);

  if (TDstI < MinW) begin : g_width_check
    $error("TDstI too narrow for SIMD*SF result range");
  end

  logic [AccW-1:0]  r_acc;
  logic [CntW-1:0]  r_cnt;
  logic [TDstI-1:0] r_out_dat;
  logic             r_out_valid;

  logic [SIMD-1:0]  w_prod;
  logic [AccW-1:0]  w_pc;
  logic [AccW-1:0]  w_sum;
  logic [TDstI-1:0] w_sum_ext;
  logic [TDstI-1:0] w_res;
  logic             w_accept;
  logic             w_last;

  // Gate lanes with in_valid so undriven data never reaches the popcount.
  assign w_prod = in_valid ? ~(in_act ^ in_wgt) : '0;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < SIMD; i++) begin
      w_pc = w_pc + AccW'(w_prod[i]);
    end
  end

  assign in_ready  = !(r_out_valid && !out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == LastCnt);
  assign w_sum     = r_acc + w_pc;
  assign w_sum_ext = TDstI'(w_sum);

`ifdef XNOR_BIPOLAR_EN
  // 2*matches - total, evaluated modulo 2^TDstI to give two's complement.
  assign w_res = (w_sum_ext << 1) - TDstI'(SIMD * SF);
`else
  assign w_res = w_sum_ext;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A LAST accept overrides the drain so results can stream with no bubble.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_out_dat   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept && w_last) begin
      r_out_dat   <= w_res;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_dat   = r_out_dat;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mvu_pe_xnor_popcount_acc.sv
// Directed bench for mvu_pe_xnor_popcount_acc with SIMD=8, SF=4, TDstI=8 (unsigned build).
module tb_mvu_pe_xnor_popcount_acc;

  logic       aclk;
  logic       areset;
  logic [7:0] in_act;
  logic [7:0] in_wgt;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_dat;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  mvu_pe_xnor_popcount_acc #(
    .SIMD (8),
    .SF   (4),
    .TDstI(8)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .in_act   (in_act),
    .in_wgt   (in_wgt),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_dat  (out_dat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one beat for one clock; inputs change 1ns after the edge.
  task automatic beat(input logic [7:0] act, input logic [7:0] wgt);
    in_act   = act;
    in_wgt   = wgt;
    in_valid = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_act   = 'x;
    in_wgt   = 'x;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    areset    = 1'b1;
    in_valid  = 1'b0;
    in_act    = '0;
    in_wgt    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_dat", out_dat, 8'd0);
    areset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // All-match row: 4 x popcount 8 = 32
    beat(8'hA5, 8'hA5);
    beat(8'hA5, 8'hA5);
    beat(8'hA5, 8'hA5);
    check("match_no_early_valid", out_valid, 1'b0);
    beat(8'hA5, 8'hA5);
    check("match_valid", out_valid, 1'b1);
    check("match_dat", out_dat, 8'd32);
    idle(1);
    check("match_pulse_clear", out_valid, 1'b0);

    // All-mismatch row
    repeat (4) beat(8'hFF, 8'h00);
    check("mismatch_valid", out_valid, 1'b1);
    check("mismatch_dat", out_dat, 8'd0);
    idle(1);

    // Mixed popcounts 3,5,0,8 with idle gaps = 16
    beat(8'h07, 8'hFF);
    idle(2);
    check("gap_no_valid", out_valid, 1'b0);
    beat(8'h1F, 8'hFF);
    idle(1);
    beat(8'hFF, 8'h00);
    idle(3);
    check("gap_no_valid2", out_valid, 1'b0);
    beat(8'h00, 8'h00);
    check("gap_valid", out_valid, 1'b1);
    check("gap_dat", out_dat, 8'd16);
    idle(1);

    // Backpressure: first result 32 held, second row popcount 7 each = 28
    out_ready = 1'b0;
    repeat (4) beat(8'hA5, 8'hA5);
    check("bp_first_valid", out_valid, 1'b1);
    check("bp_first_dat", out_dat, 8'd32);
    in_act   = 8'h00;
    in_wgt   = 8'h01;
    in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    repeat (3) @(posedge aclk);
    #1;
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_hold_dat", out_dat, 8'd32);
    check("bp_hold_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    beat(8'h00, 8'h01);
    check("bp_drained", out_valid, 1'b0);
    beat(8'h00, 8'h01);
    beat(8'h00, 8'h01);
    check("bp_no_early_second", out_valid, 1'b0);
    beat(8'h00, 8'h01);
    check("bp_second_valid", out_valid, 1'b1);
    check("bp_second_dat", out_dat, 8'd28);
    idle(1);
    check("bp_second_clear", out_valid, 1'b0);

    // Back-to-back rows with popcounts 8, 4, 2 -> 32, 16, 8
    for (int k = 0; k < 12; k++) begin
      logic [7:0] act;
      logic [7:0] exp_dat;
      act     = (k < 4) ? 8'h00 : ((k < 8) ? 8'h0F : 8'h3F);
      exp_dat = (k < 4) ? 8'd32 : ((k < 8) ? 8'd16 : 8'd8);
      beat(act, 8'h00);
      check("b2b_in_ready", in_ready, 1'b1);
      check("b2b_valid", out_valid, (k % 4 == 3) ? 1'b1 : 1'b0);
      if (k % 4 == 3) check("b2b_dat", out_dat, exp_dat);
    end
    idle(1);
    check("b2b_end_clear", out_valid, 1'b0);

    // Pending result dropped asynchronously by reset
    out_ready = 1'b0;
    repeat (4) beat(8'hA5, 8'hA5);
    check("rst_pend_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #1;
    areset = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_dat", out_dat, 8'd0);
    #1;
    areset    = 1'b0;
    out_ready = 1'b1;
    @(posedge aclk);
    #1;

    // Reset mid-fold discards partial sum: 8,8 then reset, then 4 x popcount 1 = 4
    beat(8'hA5, 8'hA5);
    beat(8'hA5, 8'hA5);
    in_valid = 1'b0;
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
    check("midfold_in_ready", in_ready, 1'b1);
    beat(8'h00, 8'hFE);
    beat(8'h00, 8'hFE);
    beat(8'h00, 8'hFE);
    check("midfold_no_early", out_valid, 1'b0);
    beat(8'h00, 8'hFE);
    check("midfold_valid", out_valid, 1'b1);
    check("midfold_dat", out_dat, 8'd4);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
